// File: rtl/cascade_param_streamer.sv
// Walks a Haar cascade image in memory and streams its fields as tagged words
// in evaluator order, through a 2-entry output FIFO with valid/ready handshake.
module cascade_param_streamer #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int STAGE_W = 8,
  parameter int CLASS_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_tag,
  output logic              out_last,
  output logic              out_eoc
);

  localparam logic [4:0] T_NSTAGES = 5'd2;
  localparam logic [4:0] T_STG_THR = 5'd3;
  localparam logic [4:0] T_NCLASS  = 5'd4;
  localparam logic [4:0] T_F1A     = 5'd5;
  localparam logic [4:0] CLS_LAST  = 5'd17;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_STG, S_CLS, S_DRAIN} state_t;

  state_t              state;
  logic [4:0]          idx;
  logic                cnt_wait;
  logic [ADDR_W-1:0]   addr;
  logic [STAGE_W-1:0]  stage_rem;
  logic [CLASS_W-1:0]  class_rem;

  logic                infl_vld;
  logic [4:0]          infl_tag;
  logic                infl_last;
  logic                infl_eoc;

  logic [DATA_W-1:0]   fifo_data [2];
  logic [4:0]          fifo_tag  [2];
  logic                fifo_last [2];
  logic                fifo_eoc  [2];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          fifo_cnt;

  logic                pop;
  logic                wr;
  logic                issue;
  logic [2:0]          occ;
  logic [1:0]          cnt_nxt;
  logic [4:0]          iss_tag;
  logic                iss_last;
  logic                iss_eoc;
  logic                w_last;
  logic                w_eoc;
  logic [STAGE_W-1:0]  rd_nstages;
  logic [CLASS_W-1:0]  rd_nclass;
  logic                final_stage;
  logic                last_cls;

  assign rd_nstages  = mem_rdata[STAGE_W-1:0];
  assign rd_nclass   = mem_rdata[CLASS_W-1:0];
  assign final_stage = (stage_rem == STAGE_W'(1));
  assign last_cls    = (class_rem == CLASS_W'(1));

  assign out_valid = (fifo_cnt != 2'd0);
  assign out_data  = fifo_data[rd_ptr];
  assign out_tag   = fifo_tag[rd_ptr];
  assign out_last  = fifo_last[rd_ptr];
  assign out_eoc   = fifo_eoc[rd_ptr];
  assign mem_rd    = issue;
  assign mem_addr  = addr;

  // Issue decision: a read may go out only if its word is guaranteed a FIFO slot,
  // counting the word already in flight and crediting this cycle's transfer.
  always_comb begin
    pop      = out_valid && out_ready && !abort;
    wr       = infl_vld && !abort;
    occ      = {1'b0, fifo_cnt} + {2'b00, infl_vld} - {2'b00, pop};
    cnt_nxt  = fifo_cnt + {1'b0, wr} - {1'b0, pop};
    issue    = 1'b0;
    if ((state == S_HDR || state == S_STG || state == S_CLS) &&
        !cnt_wait && !abort && (occ < 3'd2))
      issue = 1'b1;

    iss_tag  = 5'd0;
    iss_last = 1'b0;
    iss_eoc  = 1'b0;
    case (state)
      S_HDR: iss_tag = idx;
      S_STG: begin
        iss_tag = T_STG_THR + idx;
        // For the NCLASS word this flag records "final stage"; resolved on return.
        if (idx == 5'd1) iss_eoc = final_stage;
      end
      S_CLS: begin
        iss_tag = T_F1A + idx;
        if (idx == CLS_LAST) begin
          iss_last = last_cls;
          iss_eoc  = last_cls && final_stage;
        end
      end
      default: ;
    endcase

    w_last = infl_last;
    w_eoc  = infl_eoc;
    if (infl_tag == T_NSTAGES) begin
      w_last = 1'b0;
      w_eoc  = (rd_nstages == '0);
    end else if (infl_tag == T_NCLASS) begin
      w_last = (rd_nclass == '0);
      w_eoc  = (rd_nclass == '0) && infl_eoc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      cnt_wait  <= 1'b0;
      addr      <= '0;
      stage_rem <= '0;
      class_rem <= '0;
      infl_vld  <= 1'b0;
      infl_tag  <= '0;
      infl_last <= 1'b0;
      infl_eoc  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_tag[i]  <= '0;
        fifo_last[i] <= 1'b0;
        fifo_eoc[i]  <= 1'b0;
      end
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fifo_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort && busy) begin
      state    <= S_IDLE;
      idx      <= '0;
      cnt_wait <= 1'b0;
      infl_vld <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b1;
    end else begin
      done     <= 1'b0;
      infl_vld <= issue;
      if (issue) begin
        infl_tag  <= iss_tag;
        infl_last <= iss_last;
        infl_eoc  <= iss_eoc;
        addr      <= addr + ADDR_W'(1);
      end
      if (wr) begin
        fifo_data[wr_ptr] <= mem_rdata;
        fifo_tag[wr_ptr]  <= infl_tag;
        fifo_last[wr_ptr] <= w_last;
        fifo_eoc[wr_ptr]  <= w_eoc;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= cnt_nxt;

      case (state)
        S_IDLE: begin
          if (start && !done) begin
            state <= S_HDR;
            busy  <= 1'b1;
            addr  <= base_addr;
            idx   <= '0;
          end
        end
        S_HDR: begin
          if (issue) begin
            idx <= idx + 5'd1;
            if (idx == 5'd2) cnt_wait <= 1'b1;
          end else if (cnt_wait && infl_vld) begin
            cnt_wait  <= 1'b0;
            idx       <= '0;
            stage_rem <= rd_nstages;
            state     <= (rd_nstages == '0) ? S_DRAIN : S_STG;
          end
        end
        S_STG: begin
          if (issue) begin
            idx <= idx + 5'd1;
            if (idx == 5'd1) cnt_wait <= 1'b1;
          end else if (cnt_wait && infl_vld) begin
            cnt_wait  <= 1'b0;
            idx       <= '0;
            class_rem <= rd_nclass;
            if (rd_nclass != '0) state <= S_CLS;
            else if (final_stage) state <= S_DRAIN;
            else stage_rem <= stage_rem - STAGE_W'(1);
          end
        end
        S_CLS: begin
          if (issue) begin
            if (idx == CLS_LAST) begin
              idx <= '0;
              if (!last_cls) class_rem <= class_rem - CLASS_W'(1);
              else if (final_stage) state <= S_DRAIN;
              else begin
                stage_rem <= stage_rem - STAGE_W'(1);
                state     <= S_STG;
              end
            end else begin
              idx <= idx + 5'd1;
            end
          end
        end
        S_DRAIN: begin
          if (cnt_nxt == 2'd0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cascade_param_streamer.sv
// Bench for cascade_param_streamer: random cascade images in a memory model,
// expected word/address streams derived by walking the image structure.
module tb_cascade_param_streamer;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 16;
  localparam int STAGE_W = 8;
  localparam int CLASS_W = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              out_ready = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              busy, done, mem_rd, out_valid, out_last, out_eoc;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata, out_data;
  logic [4:0]        out_tag;

  logic [DATA_W-1:0] mem [0:65535];
  int                total = 0;
  int                bad = 0;
  logic [38:0]       expq [$];
  logic [15:0]       addrq [$];
  logic [15:0]       wa;
  logic [15:0]       ba;
  int                ncs [8];

  cascade_param_streamer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STAGE_W(STAGE_W), .CLASS_W(CLASS_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .abort(abort),
    .busy(busy), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_last(out_last), .out_eoc(out_eoc)
  );

  always #5 clk = ~clk;

  // Memory returns data one cycle after the strobe; garbage otherwise.
  always @(posedge clk) mem_rdata <= mem_rd ? mem[mem_addr] : $urandom();

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [31:0] w);
    mem[wa] = w;
    wa++;
  endtask

  task automatic make_img(input logic [15:0] base, input int ns);
    logic [31:0] r;
    wa = base;
    put($urandom());
    put($urandom());
    r = $urandom();
    r[STAGE_W-1:0] = STAGE_W'(ns);
    put(r);
    for (int s = 0; s < ns; s++) begin
      put($urandom());
      r = $urandom();
      r[CLASS_W-1:0] = CLASS_W'(ncs[s]);
      put(r);
      repeat (18 * ncs[s]) put($urandom());
    end
  endtask

  task automatic emit(input int tag, input bit l, input bit e);
    addrq.push_back(ba);
    expq.push_back({mem[ba], 5'(tag), l, e});
    ba++;
  endtask

  // Reference: read the image field by field the way the evaluator expects it.
  task automatic build(input logic [15:0] base);
    logic [31:0] w;
    int ns, nc;
    bit l;
    expq.delete();
    addrq.delete();
    ba = base;
    emit(0, 0, 0);
    emit(1, 0, 0);
    w = mem[ba];
    ns = int'(w[STAGE_W-1:0]);
    emit(2, 0, ns == 0);
    for (int s = 0; s < ns; s++) begin
      emit(3, 0, 0);
      w = mem[ba];
      nc = int'(w[CLASS_W-1:0]);
      emit(4, nc == 0, (nc == 0) && (s == ns - 1));
      for (int c = 0; c < nc; c++)
        for (int f = 0; f < 18; f++) begin
          l = (f == 17) && (c == nc - 1);
          emit(5 + f, l, l && (s == ns - 1));
        end
    end
  endtask

  function automatic logic rdy(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (c < 20) return (c % 2) == 0;
    if (c < 25) return 1'b0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_walk(input logic [15:0] base, input int mode, input bit poke,
                          input int exp_last);
    int cyc = 0, ridx = 0, widx = 0, xfer = -100, first = -1, mx = 0;
    bit got = 0, stalled = 0;
    logic [38:0] held = '0, obsw;
    base_addr = base;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!got && cyc < 4000) begin
      out_ready = rdy(mode, cyc);
      start = poke && (cyc == 10);
      if (start) base_addr = base ^ 16'h0F0F;
      @(negedge clk);
      obsw = {out_data, out_tag, out_last, out_eoc};
      if (stalled) chk("stall_hold", {24'd0, out_valid, obsw}, {24'd0, 1'b1, held});
      if (out_valid && first < 0) first = cyc;
      if (ridx - widx > mx) mx = ridx - widx;
      if (mem_rd) begin
        if (ridx < addrq.size()) chk("rd_addr", 64'(mem_addr), 64'(addrq[ridx]));
        ridx++;
      end
      if (out_valid && out_ready) begin
        if (widx < expq.size()) chk("word", 64'(obsw), 64'(expq[widx]));
        widx++;
        xfer = cyc;
      end
      if (done) begin
        got = 1;
        chk("done_after_last", 64'(cyc), 64'(xfer + 1));
        chk("busy_at_done", 64'(busy), 64'd0);
      end
      stalled = out_valid && !out_ready;
      held = obsw;
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    start = 1'b0;
    chk("done_seen", 64'(got), 64'd1);
    chk("first_valid_cycle", 64'(first), 64'd2);
    chk("word_count", 64'(widx), 64'(expq.size()));
    chk("read_count", 64'(ridx), 64'(addrq.size()));
    chk("max_outstanding_le2", 64'(mx <= 2), 64'd1);
    if (exp_last >= 0) chk("last_xfer_cycle", 64'(xfer), 64'(exp_last));
  endtask

  initial begin
    int widx, cyc;
    logic [15:0] rb;
    // Reset values
    #12;
    chk("reset_outputs", {busy, done, mem_rd, mem_addr, out_valid, out_data, out_tag, out_last, out_eoc},
        64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Abort while idle is ignored
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_ignored", {done, busy, out_valid}, 64'd0);
    @(posedge clk); #1;

    // 1 stage, 1 classifier, full rate
    ncs[0] = 1;
    make_img(16'h0100, 1);
    build(16'h0100);
    run_walk(16'h0100, 0, 0, 26);

    // 2 stages with 2 and 0 classifiers; start while busy must be ignored
    ncs[0] = 2; ncs[1] = 0;
    make_img(16'h0400, 2);
    build(16'h0400);
    chk("walk2_len", 64'(expq.size()), 64'd43);
    run_walk(16'h0400, 0, 1, 46);

    // Address wrap with zero stages
    make_img(16'hFFFE, 0);
    build(16'hFFFE);
    run_walk(16'hFFFE, 0, 0, 4);

    // Random shapes with toggled / stalled ready
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 3; s++) ncs[s] = $urandom_range(0, 2);
      rb = 16'($urandom_range(16'h1000, 16'hE000));
      make_img(rb, 3);
      build(rb);
      run_walk(rb, 1, 0, -1);
    end

    // Abort during the 2nd classifier with the FIFO full
    ncs[0] = 3; ncs[1] = 1;
    make_img(16'h0200, 2);
    build(16'h0200);
    base_addr = 16'h0200;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    widx = 0;
    cyc = 0;
    while (widx < 26 && cyc < 200) begin
      out_ready = 1'b1;
      @(negedge clk);
      if (out_valid && out_ready) begin
        chk("abort_pre_word", 64'({out_data, out_tag, out_last, out_eoc}), 64'(expq[widx]));
        widx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("abort_reached_cls2", 64'(widx), 64'd26);
    out_ready = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("full_vld_no_rd", {out_valid, mem_rd}, 64'b10);
    @(posedge clk); #1;
    abort = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("abort_cycle_no_rd", 64'(mem_rd), 64'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk("after_abort_done", {done, busy, out_valid, mem_rd}, 64'b1000);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_on_done_ignored", {done, busy, out_valid, mem_rd}, 64'd0);
    @(posedge clk); #1;
    run_walk(16'h0200, 0, 0, -1);

    // Reset mid-stage, then a fresh walk
    ncs[0] = 2;
    make_img(16'h3000, 1);
    build(16'h3000);
    base_addr = 16'h3000;
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_walk_reset", {busy, done, mem_rd, mem_addr, out_valid, out_data, out_tag, out_last, out_eoc},
        64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    run_walk(16'h3000, 0, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
